// File: rtl/gnr_ctrl_pkg.sv
// Shared types and defaults for the gene-regulatory-network attractor controller.
package gnr_ctrl_pkg;

  localparam int unsigned DefCntW    = 16;
  localparam logic [15:0] DefMaxIter = 16'hFFFF;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StRunA,
    StRunB,
    StRunChk,
    StPerStep,
    StPerChk,
    StMuLoad,
    StMuAdv,
    StMuChk,
    StMuA,
    StMuB,
    StFin
  } gnr_state_e;

endpackage

// File: rtl/gnr_sat_counter.sv
// Saturating up-counter with synchronous clear; nxt_o is the value an increment would produce.
module gnr_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] nxt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;
  assign nxt_o = sat_o ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= nxt_o;
    end
  end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection initiator for a boolean gene-regulatory network node array.
// Optional transient (mu) measurement is built when GNR_TRANSIENT_EN is defined.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int unsigned      N_NODES  = 8,
  parameter int unsigned      CNT_W    = DefCntW,
  parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(DefMaxIter)
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [N_NODES-1:0] init_vec_i,
  input  logic [N_NODES-1:0] s0_vec_i,
  input  logic [N_NODES-1:0] s1_vec_i,
  output logic               reset_nos_o,
  output logic               start_s0_o,
  output logic               start_s1_o,
  output logic [N_NODES-1:0] init_state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   period_o,
  output logic [N_NODES-1:0] attractor_o,
  output logic [CNT_W-1:0]   transient_o
);

  gnr_state_e       state_q;
  logic             reset_nos_q, start_s0_q, start_s1_q;
  logic             busy_q, done_q, timeout_q;
  logic [N_NODES-1:0] init_state_q, attractor_q;
  logic [CNT_W-1:0] period_q;

  logic             iter_clr, iter_inc, iter_sat;
  logic [CNT_W-1:0] iter_cnt, iter_nxt;
  logic             cnt_clr, cnt_inc, cnt_sat;
  logic [CNT_W-1:0] cnt_cnt, cnt_nxt;
  logic             match;

  assign match = (s0_vec_i == s1_vec_i);

  // Node outputs are only trusted in states that issued no enable this cycle.
  always_comb begin
    iter_clr = 1'b0;
    iter_inc = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      StLoad:    iter_clr = 1'b1;
      StRunChk:  begin
        iter_inc = 1'b1;
        cnt_clr  = match;
      end
      StPerStep: cnt_inc = 1'b1;
      StMuLoad:  begin
        iter_clr = 1'b1;
        cnt_clr  = 1'b1;
      end
      StMuAdv:   iter_inc = 1'b1;
      StMuB:     cnt_inc = 1'b1;
      default:   ;
    endcase
  end

  gnr_sat_counter #(.CNT_W(CNT_W)) u_iter (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (iter_clr),
    .inc_i (iter_inc),
    .cnt_o (iter_cnt),
    .nxt_o (iter_nxt),
    .sat_o (iter_sat)
  );

  gnr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt_cnt),
    .nxt_o (cnt_nxt),
    .sat_o (cnt_sat)
  );

`ifdef GNR_TRANSIENT_EN
  logic [CNT_W-1:0] transient_q;
  assign transient_o = transient_q;
`else
  assign transient_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      reset_nos_q  <= 1'b0;
      start_s0_q   <= 1'b0;
      start_s1_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      init_state_q <= '0;
      attractor_q  <= '0;
      period_q     <= '0;
`ifdef GNR_TRANSIENT_EN
      transient_q  <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            init_state_q <= init_vec_i;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            period_q     <= '0;
            busy_q       <= 1'b1;
            reset_nos_q  <= 1'b1;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          reset_nos_q <= 1'b0;
          start_s0_q  <= 1'b1;
          start_s1_q  <= 1'b1;
          state_q     <= StRunA;
        end
        StRunA: state_q <= StRunB;
        StRunB: begin
          start_s0_q <= 1'b0;
          start_s1_q <= 1'b0;
          state_q    <= StRunChk;
        end
        StRunChk: begin
          if (match) begin
            attractor_q <= s0_vec_i;
            start_s1_q  <= 1'b1;
            state_q     <= StPerStep;
          end else if (iter_nxt == MAX_ITER || iter_sat) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StFin;
          end else begin
            start_s0_q <= 1'b1;
            start_s1_q <= 1'b1;
            state_q    <= StRunA;
          end
        end
        StPerStep: begin
          start_s1_q <= 1'b0;
          state_q    <= StPerChk;
        end
        StPerChk: begin
          if (s1_vec_i == attractor_q) begin
            period_q <= cnt_cnt;
`ifdef GNR_TRANSIENT_EN
            reset_nos_q <= 1'b1;
            state_q     <= StMuLoad;
`else
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFin;
`endif
          end else if (cnt_sat) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StFin;
          end else begin
            start_s1_q <= 1'b1;
            state_q    <= StPerStep;
          end
        end
`ifdef GNR_TRANSIENT_EN
        StMuLoad: begin
          reset_nos_q <= 1'b0;
          start_s1_q  <= 1'b1;
          state_q     <= StMuAdv;
        end
        // Hare is pushed exactly period steps ahead of the reloaded tortoise.
        StMuAdv: begin
          if (iter_nxt == period_q) begin
            start_s1_q <= 1'b0;
            state_q    <= StMuChk;
          end
        end
        StMuChk: begin
          if (match) begin
            transient_q <= cnt_cnt;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StFin;
          end else if (cnt_sat) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StFin;
          end else begin
            start_s0_q <= 1'b1;
            start_s1_q <= 1'b1;
            state_q    <= StMuA;
          end
        end
        StMuA: begin
          start_s1_q <= 1'b0;
          state_q    <= StMuB;
        end
        StMuB: begin
          start_s0_q <= 1'b0;
          state_q    <= StMuChk;
        end
`endif
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reset_nos_o  = reset_nos_q;
  assign start_s0_o   = start_s0_q;
  assign start_s1_o   = start_s1_q;
  assign init_state_o = init_state_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign period_o     = period_q;
  assign attractor_o  = attractor_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench: behavioural node array with pass semantics drives the controller.
module tb_gnr_attractor_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  init_vec_i = 8'd0;
  logic [7:0]  s0_vec_i, s1_vec_i;
  logic        reset_nos_o, start_s0_o, start_s1_o;
  logic [7:0]  init_state_o, attractor_o;
  logic        busy_o, done_o, timeout_o;
  logic [15:0] period_o, transient_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit inc_mode = 1'b0;

  logic [7:0] m_s0 = 8'd0;
  logic [7:0] m_s1 = 8'd0;
  logic       m_pass = 1'b1;

  always #5 clk_i = ~clk_i;

  gnr_attractor_ctrl #(
    .N_NODES  (8),
    .CNT_W    (16),
    .MAX_ITER (16'd10)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .init_vec_i   (init_vec_i),
    .s0_vec_i     (s0_vec_i),
    .s1_vec_i     (s1_vec_i),
    .reset_nos_o  (reset_nos_o),
    .start_s0_o   (start_s0_o),
    .start_s1_o   (start_s1_o),
    .init_state_o (init_state_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o),
    .period_o     (period_o),
    .attractor_o  (attractor_o),
    .transient_o  (transient_o)
  );

  function automatic logic [7:0] f(input logic [7:0] x);
    if (inc_mode) return x + 8'd1;
    case (x)
      8'd0:    return 8'd1;
      8'd1:    return 8'd2;
      8'd2:    return 8'd3;
      8'd3:    return 8'd4;
      8'd4:    return 8'd2;
      8'd7:    return 8'd7;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (reset_nos_o) begin
      m_s0   <= init_state_o;
      m_s1   <= init_state_o;
      m_pass <= 1'b1;
    end else begin
      if (start_s0_o) begin
        if (m_pass) m_s0 <= f(m_s0);
        m_pass <= ~m_pass;
      end
      if (start_s1_o) m_s1 <= f(m_s1);
    end
  end

  assign s0_vec_i = m_s0;
  assign s1_vec_i = m_s1;

  task automatic run(input logic [7:0] v, output int cyc, output bit ok);
    @(negedge clk_i);
    start_i    = 1'b1;
    init_vec_i = v;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    while (!done_o && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
    end
    ok = done_o;
  endtask

  task automatic check_result(input string name, input bit ok, input logic [15:0] per,
                              input logic [7:0] att, input logic [15:0] mu);
    n_cmp++;
    if (ok !== 1'b1 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s flags: done=%b timeout=%b busy=%b required 1/0/0",
               name, ok, timeout_o, busy_o);
    end
    n_cmp++;
    if (period_o !== per) begin
      n_bad++;
      $display("FAIL %s period: got %0d required %0d", name, period_o, per);
    end
    n_cmp++;
    if (attractor_o !== att) begin
      n_bad++;
      $display("FAIL %s attractor: got %0d required %0d", name, attractor_o, att);
    end
    n_cmp++;
    if (transient_o !== mu) begin
      n_bad++;
      $display("FAIL %s transient: got %0d required %0d", name, transient_o, mu);
    end
  endtask

  function automatic logic [15:0] mu_exp(input logic [15:0] mu);
`ifdef GNR_TRANSIENT_EN
    return mu;
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset();
    @(negedge clk_i);
    n_cmp++;
    if ({reset_nos_o, start_s0_o, start_s1_o, busy_o, done_o, timeout_o} !== 6'b0 ||
        init_state_o !== 8'd0 || attractor_o !== 8'd0 || period_o !== 16'd0 ||
        transient_o !== 16'd0) begin
      n_bad++;
      $display("FAIL reset outputs: ctl=%b init=%0d att=%0d per=%0d mu=%0d required all 0",
               {reset_nos_o, start_s0_o, start_s1_o, busy_o, done_o, timeout_o},
               init_state_o, attractor_o, period_o, transient_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cycle();
    int cyc; bit ok;
    run(8'd0, cyc, ok);
    check_result("init0", ok, 16'd3, 8'd3, mu_exp(16'd2));
  endtask

  task automatic test_tail();
    int cyc; bit ok;
    run(8'd5, cyc, ok);
    check_result("init5", ok, 16'd3, 8'd2, mu_exp(16'd3));
  endtask

  task automatic test_fixed_point();
    int cyc; bit ok;
    run(8'd7, cyc, ok);
    check_result("fixed7", ok, 16'd1, 8'd7, 16'd0);
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    inc_mode = 1'b1;
    run(8'd0, cyc, ok);
    n_cmp++;
    if (ok !== 1'b1 || timeout_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout flags: done=%b timeout=%b busy=%b required 1/1/0",
               ok, timeout_o, busy_o);
    end
    // start edge + LOAD + 10 x (RUN_A, RUN_B, RUN_CHK) + FIN
    n_cmp++;
    if (cyc != 32) begin
      n_bad++;
      $display("FAIL timeout latency: got %0d cycles required 32", cyc);
    end
    inc_mode = 1'b0;
  endtask

  task automatic test_midrun_reset();
    int cyc; bit ok;
    @(negedge clk_i);
    start_i    = 1'b1;
    init_vec_i = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b1 || start_s0_o !== 1'b1 || start_s1_o !== 1'b1) begin
      n_bad++;
      $display("FAIL run_b enables: busy=%b s0=%b s1=%b required 1/1/1",
               busy_o, start_s0_o, start_s1_o);
    end
    rst_n = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({reset_nos_o, start_s0_o, start_s1_o, busy_o, done_o, timeout_o} !== 6'b0 ||
        init_state_o !== 8'd0 || period_o !== 16'd0 || attractor_o !== 8'd0) begin
      n_bad++;
      $display("FAIL midrun reset: ctl=%b init=%0d per=%0d att=%0d required all 0",
               {reset_nos_o, start_s0_o, start_s1_o, busy_o, done_o, timeout_o},
               init_state_o, period_o, attractor_o);
    end
    rst_n = 1'b1;
    run(8'd0, cyc, ok);
    check_result("after_reset", ok, 16'd3, 8'd3, mu_exp(16'd2));
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk_i);
    start_i    = 1'b1;
    init_vec_i = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    start_i    = 1'b1;
    init_vec_i = 8'h55;
    @(negedge clk_i);
    start_i = 1'b0;
    n_cmp++;
    if (init_state_o !== 8'd0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL busy start: init_state=%0d busy=%b required 0/1", init_state_o, busy_o);
    end
    cyc = 0;
    while (!done_o && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
    end
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || period_o !== 16'd3) begin
      n_bad++;
      $display("FAIL busy run: done=%b busy=%b period=%0d required 1/0/3",
               done_o, busy_o, period_o);
    end
    // This negedge is inside the FIN cycle: the start seen at the next edge must be dropped.
    start_i    = 1'b1;
    init_vec_i = 8'd7;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0 || init_state_o !== 8'd0 || done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL start in fin: busy=%b init_state=%0d done=%b required 0/0/1",
               busy_o, init_state_o, done_o);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1 || init_state_o !== 8'd7 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL start after fin: busy=%b init_state=%0d done=%b required 1/7/0",
               busy_o, init_state_o, done_o);
    end
    cyc = 0;
    while (!done_o && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
    end
    n_cmp++;
    if (done_o !== 1'b1 || period_o !== 16'd1 || attractor_o !== 8'd7) begin
      n_bad++;
      $display("FAIL second run: done=%b period=%0d attractor=%0d required 1/1/7",
               done_o, period_o, attractor_o);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_tail();
    test_fixed_point();
    test_timeout();
    test_midrun_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
